mem_arbiter: RTL

- Shares one single-port, synchronous-read unified memory between the fetch stage (instruction reads) and the memory stage (loads and stores).
- Sits between the pipeline stages and the memory macro.
- Grants at most one access per cycle and returns read data one cycle after the grant.
- Raises per-stage stall outputs, so the pipeline holds any requester that loses arbitration.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_store_lane_gen.sv | 44 ++++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and store-size encodings for the unified-memory arbiter.
package mem_arbiter_pkg;

  localparam int DATA_DEPTH = 1024;
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
  localparam int REG_WIDTH  = 32;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_e;

endpackage

// File: rtl/mem_arbiter_store_lane_gen.sv
// Maps a store's size and byte offset onto memory byte enables and lane-aligned data.
module mem_arbiter_store_lane_gen
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic        misalign
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    be       = 4'b0000;
    wdata_al = '0;
    misalign = 1'b0;
    case (store_funct3_e'(funct3))
      F3_SB: begin
        be       = 4'b0001 << addr_lo;
        wdata_al = {4{wdata[7:0]}};
      end
      F3_SH: begin
        if (addr_lo[0]) begin
          misalign = 1'b1;
        end else begin
          be       = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_al = {2{wdata[15:0]}};
        end
      end
      F3_SW: begin
        if (addr_lo != 2'b00) begin
          misalign = 1'b1;
        end else begin
          be       = 4'b1111;
          wdata_al = wdata;
        end
      end
      // Reserved sizes are rejected like a misaligned store.
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data stage wins by default, fetch wins once it has
// been starved STARVE_LIMIT cycles; read data returns one cycle after the grant.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = mem_arbiter_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = mem_arbiter_pkg::REG_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH+1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_funct3,
  input  logic [ADDR_WIDTH+1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_en,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall_if,
  output logic                  stall_mem
);

  import mem_arbiter_pkg::*;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [1:0]            resp_tag_q, resp_tag_d;   // {if_pending, d_pending}
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;

  logic                  if_gnt_c, d_gnt_c, d_err_c, mem_en_c;
  logic [3:0]            mem_be_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata;
  logic                  st_misalign;

  mem_arbiter_store_lane_gen u_lane_gen (
    .funct3   (d_funct3),
    .addr_lo  (d_addr[1:0]),
    .wdata    (d_wdata),
    .be       (st_be),
    .wdata_al (st_wdata),
    .misalign (st_misalign)
  );

  always_comb begin
    if_gnt_c     = 1'b0;
    d_gnt_c      = 1'b0;
    d_err_c      = 1'b0;
    mem_en_c     = 1'b0;
    mem_be_c     = 4'b0000;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    starve_cnt_d = starve_cnt_q;

    if (if_req && (!d_req || starve_cnt_q == CNT_MAX)) begin
      if_gnt_c = 1'b1;
    end else if (d_req) begin
      d_gnt_c = 1'b1;
    end

    if (if_gnt_c) begin
      mem_en_c   = 1'b1;
      mem_addr_c = if_addr[ADDR_WIDTH+1:2];
    end else if (d_gnt_c) begin
      mem_addr_c = d_addr[ADDR_WIDTH+1:2];
      if (d_we && st_misalign) begin
        d_err_c = 1'b1;
      end else begin
        mem_en_c = 1'b1;
        if (d_we) begin
          mem_be_c    = st_be;
          mem_wdata_c = st_wdata;
        end
      end
    end

    resp_tag_d = {if_gnt_c, d_gnt_c & ~d_we};

    if (!if_req || if_gnt_c) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_tag_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      resp_tag_q   <= resp_tag_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign if_gnt    = if_gnt_c & rst;
  assign d_gnt     = d_gnt_c & rst;
  assign d_err     = d_err_c & rst;
  assign mem_en    = mem_en_c & rst;
  assign mem_be    = rst ? mem_be_c : 4'b0000;
  assign mem_addr  = rst ? mem_addr_c : '0;
  assign mem_wdata = rst ? mem_wdata_c : '0;
  assign stall_if  = if_req & ~if_gnt & rst;
  assign stall_mem = d_req & ~d_gnt & rst;

  assign if_rvalid = resp_tag_q[1];
  assign d_rvalid  = resp_tag_q[0];
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule
